// File: rtl/spi_master_sel.sv
// SPI engine for the board-level fan-out: drives sclk/mosi/sen and captures the wired-OR miso.
// Latency: busy rises one cycle after start; busy lasts (2*len+2)*(div+1) cycles; done pulses one cycle later.
// Backpressure: start is only accepted while idle; requests while busy are dropped, and software polls busy/done.
// The optional SPI_IRQ_EN build adds a sticky irq output with an irq_clr input.
module spi_master_sel #(
  parameter int NUM_SS = 9,
  parameter int DIV_W  = 16
) (
  input  logic              wb_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_SS-1:0] ss_sel,
  input  logic [5:0]        len,
  input  logic [DIV_W-1:0]  div,
  input  logic              tx_neg,
  input  logic              rx_neg,
  input  logic [31:0]       tx_data,
  output logic [31:0]       rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] sen,
  input  logic              miso
`ifdef SPI_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [5:0]       len_q;
  logic [31:0]      tx_q;
  logic             txn_q;
  logic             rxn_q;
  logic [6:0]       hp;
  logic [4:0]       tx_idx;
  logic [31:0]      rx_sh;

  logic             len_ok;
  logic [4:0]       len_idx;
  logic             accept;
  logic             cnt_last;
  logic             hp_last;
  logic             hold_end;
  logic             edge_fire;
  logic             edge_rise;
  logic             tx_edge;
  logic             rx_edge;
  logic             done_nxt;

  // A length of 32 wraps to 0 in the low five bits, so subtracting one still yields index 31.
  assign len_ok   = (len != 6'd0) && (len <= 6'd32);
  assign len_idx  = len[4:0] - 5'd1;
  assign accept   = (state == IDLE) && start && len_ok;

  // One half-period is div+1 cycles; cnt_last marks the final cycle of the current half-period.
  assign cnt_last = (cnt == div_q);
  assign hp_last  = (hp == ({len_q, 1'b0} - 7'd1));
  assign hold_end = (state == HOLD) && cnt_last;

  // The first sclk edge is the rise that ends SETUP; the last is the fall that begins the final
  // half-period, so the final SHIFT half-period ends without an edge and sclk stays low into HOLD.
  assign edge_fire = cnt_last && ((state == SETUP) || ((state == SHIFT) && !hp_last));
  assign edge_rise = ~sclk;
  assign tx_edge   = edge_fire && (edge_rise == ~txn_q);
  assign rx_edge   = edge_fire && (edge_rise == ~rxn_q);

  // A zero-length request completes immediately without ever raising busy.
  assign done_nxt  = ((state == IDLE) && start && (len == 6'd0)) || hold_end;

  // Sequence the transfer phases: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)              state <= SETUP;
        SETUP:   if (cnt_last)            state <= SHIFT;
        SHIFT:   if (cnt_last && hp_last) state <= HOLD;
        HOLD:    if (cnt_last)            state <= IDLE;
        default:                          state <= IDLE;
      endcase
    end
  end

  // Capture the transfer parameters at accept so later input changes cannot disturb a transfer.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= 6'd0;
      div_q <= '0;
      tx_q  <= 32'd0;
      txn_q <= 1'b0;
      rxn_q <= 1'b0;
    end else if (accept) begin
      len_q <= len;
      div_q <= div;
      tx_q  <= tx_data;
      txn_q <= tx_neg;
      rxn_q <= rx_neg;
    end
  end

  // Half-period divider; wraps after div+1 cycles, so an all-ones div simply counts the full range.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == IDLE) || cnt_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Count completed SHIFT half-periods to know when the 2*len-th one has elapsed.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      hp <= 7'd0;
    end else if (accept) begin
      hp <= 7'd0;
    end else if ((state == SHIFT) && cnt_last && !hp_last) begin
      hp <= hp + 7'd1;
    end
  end

  // Serial clock: toggles on every edge event and otherwise holds, idling low.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
    end else if (accept) begin
      sclk <= 1'b0;
    end else if (edge_fire) begin
      sclk <= ~sclk;
    end
  end

  // MSB-first data out: first bit presented at accept, then step down on each tx edge until bit 0.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi   <= 1'b0;
      tx_idx <= 5'd0;
    end else if (accept) begin
      mosi   <= tx_data[len_idx];
      tx_idx <= len_idx;
    end else if (tx_edge && (tx_idx != 5'd0)) begin
      mosi   <= tx_q[tx_idx - 5'd1];
      tx_idx <= tx_idx - 5'd1;
    end
  end

  // Receive shift register; clearing at accept leaves the result right-justified with zero upper bits.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh <= 32'd0;
    end else if (accept) begin
      rx_sh <= 32'd0;
    end else if (rx_edge) begin
      rx_sh <= {rx_sh[30:0], miso};
    end
  end

  // Status and chip enables; rx_data only moves when a transfer finishes.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      sen     <= '1;
      rx_data <= 32'd0;
    end else begin
      done <= done_nxt;
      if (accept) begin
        busy <= 1'b1;
        sen  <= ~ss_sel;
      end else if (hold_end) begin
        busy    <= 1'b0;
        sen     <= '1;
        rx_data <= rx_sh;
      end
    end
  end

`ifdef SPI_IRQ_EN
  // Sticky completion flag; a clear in the same cycle as a set (or during the done cycle) loses.
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (done_nxt || done) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_sel.sv
// Bench for spi_master_sel: directed and randomized transfers scored against a bit-level SPI reference.
// Clock period 10; inputs change just after the rising edge or on the falling edge, outputs sampled on the falling edge.
// Every wait on the DUT is bounded; a missed done shows up as a FAIL line.
module tb_spi_master_sel;

  logic        wb_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [8:0]  ss_sel = 9'd0;
  logic [5:0]  len    = 6'd0;
  logic [15:0] div    = 16'd0;
  logic        tx_neg = 1'b0;
  logic        rx_neg = 1'b0;
  logic [31:0] tx_data = 32'd0;
  logic [31:0] rx_data;
  logic        busy, done, sclk, mosi;
  logic [8:0]  sen;
  logic        miso;
  logic        loop_en  = 1'b1;
  logic        miso_drv = 1'b0;
`ifdef SPI_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  assign miso = loop_en ? mosi : miso_drv;

  spi_master_sel #(.NUM_SS(9), .DIV_W(16)) dut (
    .wb_clk  (wb_clk),
    .rst_n   (rst_n),
    .start   (start),
    .ss_sel  (ss_sel),
    .len     (len),
    .div     (div),
    .tx_neg  (tx_neg),
    .rx_neg  (rx_neg),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .sen     (sen),
    .miso    (miso)
`ifdef SPI_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  always #5 wb_clk = ~wb_clk;

  int errs   = 0;
  int checks = 0;

  // Measurements from the most recent transfer.
  int   m_busy, m_rises, m_hi_min, m_hi_max, m_per_min, m_per_max;
  bit   m_sen_ok, m_got_done;
  logic m_mosi0;

  // Reference: walk the 2*len sclk edges (rise first). On a sampling edge the current bit is
  // captured, then on a launching edge the bit pointer moves down while bits remain.
  function automatic logic [31:0] model_rx(input int l, input logic [31:0] tx, input logic tn, input logic rn);
    logic [31:0] rx = 32'd0;
    int idx = l - 1;
    for (int e = 0; e < 2 * l; e++) begin
      bit rise = (e % 2 == 0);
      if (rise == !rn) rx = {rx[30:0], tx[idx]};
      if ((rise == !tn) && (idx > 0)) idx--;
    end
    return rx;
  endfunction

  // Issue one transfer and observe it cycle by cycle until done. With b2b set the caller is already
  // in the done cycle of a previous transfer. At cycle 'disturb' a rogue start with altered inputs is injected.
  task automatic run_xfer(input logic [5:0] l, input logic [15:0] d, input logic [31:0] tx,
                          input logic [8:0] ss, input logic tn, input logic rn,
                          input bit b2b, input int disturb);
    int   hi_run = 0;
    int   last_rise = -1;
    logic prev_sclk = 1'b0;
    if (!b2b) begin
      @(posedge wb_clk);
      #1;
    end
    len = l; div = d; tx_data = tx; ss_sel = ss; tx_neg = tn; rx_neg = rn; start = 1'b1;
    @(posedge wb_clk);
    #1 start = 1'b0;
    m_busy = 0; m_rises = 0; m_sen_ok = 1'b1; m_got_done = 1'b0;
    m_hi_min = 1 << 30; m_hi_max = 0; m_per_min = 1 << 30; m_per_max = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge wb_clk);
      if (cyc == disturb) begin
        start = 1'b1; tx_data = ~tx; len = 6'd3; div = 16'd0; ss_sel = ~ss; tx_neg = ~tn; rx_neg = ~rn;
      end else if (cyc == disturb + 1) begin
        start = 1'b0;
      end
      if (cyc == 0) m_mosi0 = mosi;
      if (busy) begin
        m_busy++;
        if (sen !== ~ss) m_sen_ok = 1'b0;
      end else if (sen !== 9'h1FF) begin
        m_sen_ok = 1'b0;
      end
      if (sclk && !prev_sclk) begin
        m_rises++;
        if (last_rise >= 0) begin
          if (cyc - last_rise < m_per_min) m_per_min = cyc - last_rise;
          if (cyc - last_rise > m_per_max) m_per_max = cyc - last_rise;
        end
        last_rise = cyc;
      end
      if (sclk) begin
        hi_run++;
      end else if (prev_sclk) begin
        if (hi_run < m_hi_min) m_hi_min = hi_run;
        if (hi_run > m_hi_max) m_hi_max = hi_run;
        hi_run = 0;
      end
      prev_sclk = sclk;
      if (done) begin
        m_got_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (sclk !== 1'b0)      begin errs++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (sen !== 9'h1FF)     begin errs++; $display("FAIL reset_sen: got %h want 1ff", sen); end
    checks++; if (busy !== 1'b0)      begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (mosi !== 1'b0)      begin errs++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (rx_data !== 32'd0)  begin errs++; $display("FAIL reset_rx: got %h want 0", rx_data); end
`ifdef SPI_IRQ_EN
    checks++; if (irq !== 1'b0)       begin errs++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    @(negedge wb_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_xfer(6'd8, 16'd0, 32'h000000A5, 9'h002, 1'b1, 1'b0, 1'b0, -1);
    checks++; if (!m_got_done)            begin errs++; $display("FAIL basic_done: got no done, want done"); end
    checks++; if (m_busy != 18)           begin errs++; $display("FAIL basic_busy: got %0d want 18", m_busy); end
    checks++; if (m_rises != 8)           begin errs++; $display("FAIL basic_rises: got %0d want 8", m_rises); end
    checks++; if (!m_sen_ok)              begin errs++; $display("FAIL basic_sen: got wrong sen, want 1fd while busy"); end
    checks++; if (m_mosi0 !== 1'b1)       begin errs++; $display("FAIL basic_mosi0: got %b want 1", m_mosi0); end
    checks++; if (rx_data !== 32'h000000A5) begin errs++; $display("FAIL basic_rx: got %h want 000000a5", rx_data); end
    @(negedge wb_clk);
    checks++; if (done !== 1'b0)          begin errs++; $display("FAIL basic_done_width: got %b want 0", done); end
  endtask

  task automatic test_full_width();
    run_xfer(6'd32, 16'd3, 32'hDEADBEEF, 9'h001, 1'b1, 1'b0, 1'b0, -1);
    checks++; if (m_busy != 264)          begin errs++; $display("FAIL full_busy: got %0d want 264", m_busy); end
    checks++; if (m_rises != 32)          begin errs++; $display("FAIL full_rises: got %0d want 32", m_rises); end
    checks++; if (m_per_min != 8 || m_per_max != 8) begin errs++; $display("FAIL full_period: got %0d..%0d want 8", m_per_min, m_per_max); end
    checks++; if (m_hi_min != 4 || m_hi_max != 4)   begin errs++; $display("FAIL full_high: got %0d..%0d want 4", m_hi_min, m_hi_max); end
    checks++; if (rx_data !== 32'hDEADBEEF) begin errs++; $display("FAIL full_rx: got %h want deadbeef", rx_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int          l  = $urandom_range(1, 32);
      int          d  = $urandom_range(0, 3);
      logic [31:0] tx = $urandom;
      logic [8:0]  ss = (n == 0) ? 9'h000 : 9'($urandom_range(0, 511));
      logic        tn = 1'($urandom_range(0, 1));
      logic        rn = 1'($urandom_range(0, 1));
      logic [31:0] exp_rx = model_rx(l, tx, tn, rn);
      run_xfer(6'(l), 16'(d), tx, ss, tn, rn, 1'b0, -1);
      checks++; if (!m_got_done) begin errs++; $display("FAIL rand%0d_done: got no done, want done", n); end
      checks++; if (m_busy != (2 * l + 2) * (d + 1)) begin errs++; $display("FAIL rand%0d_busy: got %0d want %0d", n, m_busy, (2 * l + 2) * (d + 1)); end
      checks++; if (m_rises != l) begin errs++; $display("FAIL rand%0d_rises: got %0d want %0d", n, m_rises, l); end
      checks++; if (!m_sen_ok)    begin errs++; $display("FAIL rand%0d_sen: got wrong sen, want %h while busy", n, ~ss); end
      checks++; if (m_mosi0 !== tx[l-1]) begin errs++; $display("FAIL rand%0d_mosi0: got %b want %b", n, m_mosi0, tx[l-1]); end
      checks++; if (rx_data !== exp_rx) begin errs++; $display("FAIL rand%0d_rx: got %h want %h (len %0d tn %b rn %b)", n, rx_data, exp_rx, l, tn, rn); end
    end
  endtask

  task automatic test_len_zero();
    bit saw_busy = 1'b0;
    @(posedge wb_clk);
    #1 len = 6'd0; start = 1'b1;
    @(posedge wb_clk);
    #1 start = 1'b0;
    @(negedge wb_clk);
    if (busy) saw_busy = 1'b1;
    checks++; if (done !== 1'b1) begin errs++; $display("FAIL len0_done: got %b want 1", done); end
    @(negedge wb_clk);
    if (busy) saw_busy = 1'b1;
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL len0_done_width: got %b want 0", done); end
    repeat (3) begin
      @(negedge wb_clk);
      if (busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy) begin errs++; $display("FAIL len0_busy: got busy=1, want busy never high"); end
  endtask

  task automatic test_ignore_busy();
    bit stray = 1'b0;
    run_xfer(6'd8, 16'd1, 32'h0000003C, 9'h010, 1'b1, 1'b0, 1'b0, 8);
    checks++; if (m_busy != 36)           begin errs++; $display("FAIL ignore_busy_len: got %0d want 36", m_busy); end
    checks++; if (!m_sen_ok)              begin errs++; $display("FAIL ignore_sen: got wrong sen, want 1ef while busy"); end
    checks++; if (rx_data !== 32'h0000003C) begin errs++; $display("FAIL ignore_rx: got %h want 0000003c", rx_data); end
    repeat (8) begin
      @(negedge wb_clk);
      if (busy || done) stray = 1'b1;
    end
    checks++; if (stray) begin errs++; $display("FAIL ignore_extra: got extra busy/done, want none"); end
  endtask

  task automatic test_back_to_back();
    run_xfer(6'd6, 16'd2, $urandom, 9'h080, 1'b1, 1'b0, 1'b0, -1);
    checks++; if (!m_got_done) begin errs++; $display("FAIL b2b_first_done: got no done, want done"); end
    loop_en = 1'b0; miso_drv = 1'b1;
    run_xfer(6'd1, 16'd2, 32'h0, 9'h004, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (!m_got_done)         begin errs++; $display("FAIL b2b_done: got no done, want done"); end
    checks++; if (m_busy != 12)        begin errs++; $display("FAIL b2b_busy: got %0d want 12", m_busy); end
    checks++; if (rx_data !== 32'h1)   begin errs++; $display("FAIL b2b_rx: got %h want 00000001", rx_data); end
    loop_en = 1'b1; miso_drv = 1'b0;
  endtask

`ifdef SPI_IRQ_EN
  task automatic test_irq();
    run_xfer(6'd4, 16'd0, 32'h9, 9'h100, 1'b1, 1'b0, 1'b0, -1);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set: got %b want 1", irq); end
    irq_clr = 1'b1;
    @(posedge wb_clk);
    #1 irq_clr = 1'b0;
    @(negedge wb_clk);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    @(posedge wb_clk);
    #1 irq_clr = 1'b1;
    @(posedge wb_clk);
    #1 irq_clr = 1'b0;
    @(negedge wb_clk);
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_clear: got %b want 0", irq); end
  endtask
`endif

  task automatic test_reset_mid();
    bit stray = 1'b0;
    @(posedge wb_clk);
    #1 len = 6'd16; div = 16'd1; tx_data = $urandom; ss_sel = 9'h040; tx_neg = 1'b1; rx_neg = 1'b0; start = 1'b1;
    @(posedge wb_clk);
    #1 start = 1'b0;
    repeat (12) @(negedge wb_clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (sclk !== 1'b0)     begin errs++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
    checks++; if (sen !== 9'h1FF)    begin errs++; $display("FAIL midrst_sen: got %h want 1ff", sen); end
    checks++; if (busy !== 1'b0)     begin errs++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (mosi !== 1'b0)     begin errs++; $display("FAIL midrst_mosi: got %b want 0", mosi); end
    checks++; if (rx_data !== 32'd0) begin errs++; $display("FAIL midrst_rx: got %h want 0", rx_data); end
    @(negedge wb_clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge wb_clk);
      if (busy || done) stray = 1'b1;
    end
    checks++; if (stray) begin errs++; $display("FAIL midrst_no_done: got busy/done after reset, want none"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_width();
    test_random();
    test_len_zero();
    test_ignore_busy();
    test_back_to_back();
`ifdef SPI_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion within 90000 cycles, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
